// File: rtl/wishbone_arbiter_if.sv
// Bus bundle between the requesting masters, the shared slave and the round-robin arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface wishbone_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32
);
  logic [NUM_MASTERS-1:0]            i_m_CYC;
  logic [NUM_MASTERS-1:0]            i_m_STB;
  logic [NUM_MASTERS-1:0]            i_m_WE;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] i_m_ADDR;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] i_m_DATA;
  logic [NUM_MASTERS*4-1:0]          i_m_SEL;
  logic [NUM_MASTERS-1:0]            o_m_ACK;
  logic [NUM_MASTERS-1:0]            o_m_ERR;
  logic [DATA_WIDTH-1:0]             o_m_DATA;

  logic                              o_CYC;
  logic                              o_STB;
  logic                              o_WE;
  logic [ADDR_WIDTH-1:0]             o_ADDR;
  logic [DATA_WIDTH-1:0]             o_DATA;
  logic [3:0]                        o_SEL;
  logic [DATA_WIDTH-1:0]             i_DATA;
  logic                              i_ACK;

  logic [NUM_MASTERS-1:0]            o_grant;

  modport slave (
    input  i_m_CYC, i_m_STB, i_m_WE, i_m_ADDR, i_m_DATA, i_m_SEL, i_DATA, i_ACK,
    output o_m_ACK, o_m_ERR, o_m_DATA, o_CYC, o_STB, o_WE, o_ADDR, o_DATA, o_SEL, o_grant
  );

  modport master (
    output i_m_CYC, i_m_STB, i_m_WE, i_m_ADDR, i_m_DATA, i_m_SEL, i_DATA, i_ACK,
    input  o_m_ACK, o_m_ERR, o_m_DATA, o_CYC, o_STB, o_WE, o_ADDR, o_DATA, o_SEL, o_grant
  );
endinterface

// File: rtl/wishbone_arbiter.sv
// Round-robin Wishbone arbiter: NUM_MASTERS masters share one slave port, bus held until owner drops CYC.
// Defining WB_ARB_TIMEOUT_EN adds a stall timeout that errors the owner and drains the bus.
module wishbone_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              i_CLK,
  input  logic              i_RSTN,
  wishbone_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_MASTERS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1
`ifdef WB_ARB_TIMEOUT_EN
    ,DRAIN = 2'd2
`endif
  } state_t;

  if ((NUM_MASTERS < 2) || (NUM_MASTERS > 8) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
    $error("wishbone_arbiter: NUM_MASTERS must be 2..8 and TIMEOUT_CYCLES at least 1");
  end

  logic [1:0]             rst_sync_r;
  logic                   rst_n_s;
  state_t                 state_r;
  logic [NUM_MASTERS-1:0] grant_r;
  logic [IDX_W-1:0]       owner_r;
  logic [IDX_W-1:0]       last_r;
  logic [IDX_W-1:0]       next_idx_s;
  logic [NUM_MASTERS-1:0] next_grant_s;
  logic                   req_any_s;
  int                     rr_idx_s;
  logic                   busy_s;
  logic                   owner_cyc_s;
  logic                   owner_stb_s;

  // Asynchronous assertion, two-stage synchronised release of the internal reset.
  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_n_s      = rst_sync_r[1];
  assign busy_s       = (state_r == BUSY);
  assign owner_cyc_s  = bus.i_m_CYC[owner_r];
  assign owner_stb_s  = bus.i_m_STB[owner_r];
  assign next_grant_s = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << next_idx_s;

  // Round-robin search: scanning from farthest to nearest leaves the nearest requester after last.
  always_comb begin
    next_idx_s = '0;
    req_any_s  = 1'b0;
    rr_idx_s   = 0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      rr_idx_s = (int'(last_r) + k) % NUM_MASTERS;
      if (bus.i_m_CYC[rr_idx_s]) begin
        next_idx_s = IDX_W'(rr_idx_s);
        req_any_s  = 1'b1;
      end else begin
        next_idx_s = next_idx_s;
      end
    end
  end

  // Slave-side mux: the owner drives the slave only while the bus is BUSY.
  always_comb begin
    bus.o_CYC  = 1'b0;
    bus.o_STB  = 1'b0;
    bus.o_WE   = 1'b0;
    bus.o_ADDR = '0;
    bus.o_DATA = '0;
    bus.o_SEL  = 4'h0;
    if (busy_s) begin
      bus.o_CYC  = owner_cyc_s;
      bus.o_STB  = owner_stb_s;
      bus.o_WE   = bus.i_m_WE[owner_r];
      bus.o_ADDR = bus.i_m_ADDR[int'(owner_r)*ADDR_WIDTH +: ADDR_WIDTH];
      bus.o_DATA = bus.i_m_DATA[int'(owner_r)*DATA_WIDTH +: DATA_WIDTH];
      bus.o_SEL  = bus.i_m_SEL[int'(owner_r)*4 +: 4];
    end else begin
      bus.o_CYC  = 1'b0;
    end
  end

  assign bus.o_m_ACK  = grant_r & {NUM_MASTERS{bus.i_ACK & busy_s}};
  assign bus.o_m_DATA = bus.i_DATA;
  assign bus.o_grant  = grant_r;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]       cnt_r;
  logic [NUM_MASTERS-1:0] err_r;
  assign bus.o_m_ERR = err_r;
`else
  assign bus.o_m_ERR = '0;
`endif

  // Arbitration FSM with registered grant, owner and round-robin pointer.
  always_ff @(posedge i_CLK or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_r <= IDLE;
      grant_r <= '0;
      owner_r <= '0;
      last_r  <= IDX_W'(NUM_MASTERS - 1);
`ifdef WB_ARB_TIMEOUT_EN
      cnt_r   <= '0;
      err_r   <= '0;
`endif
    end else begin
`ifdef WB_ARB_TIMEOUT_EN
      err_r <= '0;
`endif
      case (state_r)
        IDLE: begin
          if (req_any_s) begin
            state_r <= BUSY;
            grant_r <= next_grant_s;
            owner_r <= next_idx_s;
          end else begin
            grant_r <= '0;
          end
        end
        BUSY: begin
          if (!owner_cyc_s) begin
            last_r  <= owner_r;
            grant_r <= '0;
            state_r <= IDLE;
`ifdef WB_ARB_TIMEOUT_EN
            cnt_r   <= '0;
          end else if (bus.i_ACK) begin
            cnt_r   <= '0;
          end else if (owner_stb_s) begin
            // Stalled beat: the final one hands the owner an error and parks the bus.
            if (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
              cnt_r   <= '0;
              err_r   <= grant_r;
              state_r <= DRAIN;
            end else begin
              cnt_r   <= cnt_r + CNT_W'(1);
            end
          end else begin
            cnt_r   <= cnt_r;
`else
          end else begin
            state_r <= BUSY;
`endif
          end
        end
`ifdef WB_ARB_TIMEOUT_EN
        DRAIN: begin
          if (!owner_cyc_s) begin
            last_r  <= owner_r;
            grant_r <= '0;
            state_r <= IDLE;
          end else begin
            state_r <= DRAIN;
          end
        end
`endif
        default: begin
          state_r <= IDLE;
          grant_r <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wishbone_arbiter.sv
// Directed bench for wishbone_arbiter: grant-order scoreboard plus per-step immediate assertions.
// Timeout expectations switch on WB_ARB_TIMEOUT_EN.
module tb_wishbone_arbiter;
  localparam int NM = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  int checks  = 0;
  int errors  = 0;
  int err_cnt = 0;
  int ack_cnt [NM];
  logic [NM-1:0] grant_q [$];
  logic [NM-1:0] prev_grant = '0;
  logic [NM-1:0] exp_g;
  int exp_order [3] = '{0, 1, 3};

  wishbone_arbiter_if #(.NUM_MASTERS(NM), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  wishbone_arbiter #(
    .NUM_MASTERS(NM), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_CLK (clk),
    .i_RSTN(rstn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic set_m(input int i, input logic cyc, input logic stb, input logic we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
    bus.i_m_CYC[i]           = cyc;
    bus.i_m_STB[i]           = stb;
    bus.i_m_WE[i]            = we;
    bus.i_m_ADDR[i*AW +: AW] = a;
    bus.i_m_DATA[i*DW +: DW] = d;
    bus.i_m_SEL[i*4 +: 4]    = s;
  endtask

  task automatic wait_grant(input string tag);
    int n = 0;
    while ((bus.o_grant == '0) && (n < 20)) begin
      nxt();
      n++;
    end
    chk({tag, "_grant_timeout"}, 64'(n < 20), 64'd1);
  endtask

  task automatic clr_acks();
    for (int i = 0; i < NM; i++) ack_cnt[i] = 0;
  endtask

  // Monitor: tallies ACK/ERR pulses and pops the expected owner on every new grant.
  always @(negedge clk) begin
    #2;
    for (int i = 0; i < NM; i++) ack_cnt[i] += int'(bus.o_m_ACK[i]);
    err_cnt += $countones(bus.o_m_ERR);
    if ((prev_grant == '0) && (bus.o_grant != '0)) begin
      if (grant_q.size() == 0) chk("grant_unexpected", 64'(bus.o_grant), 64'd0);
      else chk("grant_order", 64'(bus.o_grant), 64'(grant_q.pop_front()));
    end
    prev_grant = bus.o_grant;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_m_CYC = '0; bus.i_m_STB = '0; bus.i_m_WE = '0;
    bus.i_m_ADDR = '0; bus.i_m_DATA = '0; bus.i_m_SEL = '0;
    bus.i_ACK = 1'b0; bus.i_DATA = '0;
    clr_acks();
    #1 rstn = 1'b0;
    nxt(); nxt();
    chk("rst_grant", 64'(bus.o_grant), 64'd0);
    chk("rst_cyc",   64'(bus.o_CYC),   64'd0);
    chk("rst_stb",   64'(bus.o_STB),   64'd0);
    chk("rst_addr",  64'(bus.o_ADDR),  64'd0);
    chk("rst_ack",   64'(bus.o_m_ACK), 64'd0);
    chk("rst_err",   64'(bus.o_m_ERR), 64'd0);

    // Single write from master 2, requested as reset is released.
    grant_q.push_back(4'b0100);
    set_m(2, 1'b1, 1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF);
    rstn = 1'b1;
    nxt();
    chk("rst_sync_edge1", 64'(bus.o_grant), 64'd0);
    wait_grant("m2");
    chk("m2_grant", 64'(bus.o_grant), 64'h4);
    chk("m2_cyc",   64'(bus.o_CYC),   64'd1);
    chk("m2_stb",   64'(bus.o_STB),   64'd1);
    chk("m2_we",    64'(bus.o_WE),    64'd1);
    chk("m2_addr",  64'(bus.o_ADDR),  64'h100);
    chk("m2_data",  64'(bus.o_DATA),  64'hDEAD_BEEF);
    chk("m2_sel",   64'(bus.o_SEL),   64'hF);
    nxt();
    chk("m2_no_early_ack", 64'(bus.o_m_ACK), 64'd0);
    bus.i_ACK = 1'b1; bus.i_DATA = 32'h1234_5678;
    #1;
    chk("m2_ack",   64'(bus.o_m_ACK),  64'h4);
    chk("m2_rdata", 64'(bus.o_m_DATA), 64'h1234_5678);
    nxt();
    bus.i_ACK = 1'b0;
    set_m(2, 1'b0, 1'b0, 1'b0, '0, '0, 4'h0);
    nxt();
    chk("m2_release_grant", 64'(bus.o_grant), 64'd0);
    chk("m2_release_cyc",   64'(bus.o_CYC),   64'd0);
    chk("m2_release_addr",  64'(bus.o_ADDR),  64'd0);
    chk("m2_ack_pulses", 64'(ack_cnt[2]), 64'd1);
    chk("m2_ack_others", 64'(ack_cnt[0] + ack_cnt[1] + ack_cnt[3]), 64'd0);

    // ACK with no owner is ignored.
    bus.i_ACK = 1'b1;
    #1;
    chk("idle_ack_ignored", 64'(bus.o_m_ACK), 64'd0);
    bus.i_ACK = 1'b0;

    // Fresh reset, then masters 0, 1, 3 collide: round-robin from master 0.
    rstn = 1'b0;
    nxt();
    rstn = 1'b1;
    nxt(); nxt(); nxt();
    clr_acks();
    grant_q.push_back(4'b0001); grant_q.push_back(4'b0010); grant_q.push_back(4'b1000);
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
    set_m(3, 1'b1, 1'b1, 1'b0, 32'h30, 32'h0, 4'hF);
    for (int j = 0; j < 3; j++) begin
      if (j == 0) wait_grant("rr");
      else nxt();
      exp_g = 4'b0001 << exp_order[j];
      chk("rr_grant", 64'(bus.o_grant), 64'(exp_g));
      chk("rr_addr",  64'(bus.o_ADDR),  64'(32'h10 * (j + 1)));
      bus.i_ACK = 1'b1;
      #1;
      chk("rr_ack", 64'(bus.o_m_ACK), 64'(exp_g));
      nxt();
      bus.i_ACK = 1'b0;
      set_m(exp_order[j], 1'b0, 1'b0, 1'b0, '0, '0, 4'h0);
      nxt();
      chk("rr_dead_cycle", 64'(bus.o_grant), 64'd0);
    end
    chk("rr_acks_m0", 64'(ack_cnt[0]), 64'd1);
    chk("rr_acks_m1", 64'(ack_cnt[1]), 64'd1);
    chk("rr_acks_m2", 64'(ack_cnt[2]), 64'd0);
    chk("rr_acks_m3", 64'(ack_cnt[3]), 64'd1);

    // Master 1 holds the bus for four beats while master 0 waits.
    clr_acks();
    grant_q.push_back(4'b0010);
    set_m(1, 1'b1, 1'b1, 1'b1, 32'h40, 32'hA5A5_0001, 4'h3);
    wait_grant("hold");
    chk("hold_grant", 64'(bus.o_grant), 64'h2);
    grant_q.push_back(4'b0001);
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h50, 32'h0, 4'hF);
    for (int b = 0; b < 4; b++) begin
      bus.i_ACK = 1'b1;
      #1;
      chk("hold_ack", 64'(bus.o_m_ACK), 64'h2);
      nxt();
      bus.i_ACK = 1'b0;
      nxt();
      chk("hold_no_preempt", 64'(bus.o_grant), 64'h2);
    end
    chk("hold_acks_m1", 64'(ack_cnt[1]), 64'd4);
    chk("hold_acks_m0", 64'(ack_cnt[0]), 64'd0);
    set_m(1, 1'b0, 1'b0, 1'b0, '0, '0, 4'h0);
    nxt();
    chk("hold_dead_cycle", 64'(bus.o_grant), 64'd0);
    nxt();
    chk("hold_m0_granted", 64'(bus.o_grant), 64'h1);

    // Asynchronous reset in the middle of master 0's strobe.
    clr_acks();
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h60, 32'h0, 4'hF);
    #2 rstn = 1'b0;
    #1;
    chk("arst_cyc",   64'(bus.o_CYC),   64'd0);
    chk("arst_stb",   64'(bus.o_STB),   64'd0);
    chk("arst_grant", 64'(bus.o_grant), 64'd0);
    bus.i_ACK = 1'b1;
    #1;
    chk("arst_no_ack", 64'(bus.o_m_ACK), 64'd0);
    chk("arst_no_err", 64'(bus.o_m_ERR), 64'd0);
    nxt();
    bus.i_ACK = 1'b0;
    grant_q.push_back(4'b0001);
    rstn = 1'b1;
    wait_grant("arst");
    chk("arst_regrant_m0", 64'(bus.o_grant), 64'h1);
    chk("arst_acks", 64'(ack_cnt[0] + ack_cnt[1]), 64'd0);
    set_m(0, 1'b0, 1'b0, 1'b0, '0, '0, 4'h0);
    set_m(1, 1'b0, 1'b0, 1'b0, '0, '0, 4'h0);
    nxt(); nxt();
    chk("arst_idle", 64'(bus.o_grant), 64'd0);

    // Master 3 read against a slave that never acknowledges.
    grant_q.push_back(4'b1000);
    set_m(3, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 4'hF);
    wait_grant("stall");
    chk("stall_grant", 64'(bus.o_grant), 64'h8);
    chk("stall_we",    64'(bus.o_WE),    64'd0);
`ifdef WB_ARB_TIMEOUT_EN
    for (int k = 0; k < TO - 1; k++) nxt();
    chk("to_no_err_yet", 64'(bus.o_m_ERR), 64'd0);
    chk("to_stb_before", 64'(bus.o_STB),   64'd1);
    nxt();
    chk("to_err_pulse",  64'(bus.o_m_ERR), 64'h8);
    chk("to_drain_stb",  64'(bus.o_STB),   64'd0);
    chk("to_drain_cyc",  64'(bus.o_CYC),   64'd0);
    chk("to_drain_grant", 64'(bus.o_grant), 64'h8);
    nxt();
    chk("to_err_single", 64'(bus.o_m_ERR), 64'd0);
    nxt(); nxt();
    chk("to_drain_held", 64'(bus.o_grant), 64'h8);
    set_m(3, 1'b0, 1'b0, 1'b0, '0, '0, 4'h0);
    nxt();
    chk("to_drain_exit", 64'(bus.o_grant), 64'd0);
    chk("to_err_total", 64'(err_cnt), 64'd1);
`else
    for (int k = 0; k < 3 * TO; k++) nxt();
    chk("stall_held_grant", 64'(bus.o_grant), 64'h8);
    chk("stall_held_cyc",   64'(bus.o_CYC),   64'd1);
    chk("stall_held_stb",   64'(bus.o_STB),   64'd1);
    chk("stall_no_err",     64'(bus.o_m_ERR), 64'd0);
    set_m(3, 1'b0, 1'b0, 1'b0, '0, '0, 4'h0);
    nxt();
    chk("stall_release", 64'(bus.o_grant), 64'd0);
    chk("stall_err_total", 64'(err_cnt), 64'd0);
`endif

    nxt();
    chk("scoreboard_empty", 64'(grant_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wishbone_arbiter.md
WISHBONE_ARBITER -- requirements
Module: wishbone_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4, meaning number of requesting masters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning data bus width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, meaning address bus width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning stall limit, used only with WB_ARB_TIMEOUT_EN.
REQ-005 SHALL have port i_CLK  in  1  sole clock; one clock; all state changes on its rising edge.
REQ-006 SHALL have port i_RSTN  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports i_m_CYC, i_m_STB, i_m_WE  in  NUM_MASTERS  per-master cycle, strobe, write-enable; bit i is master i.
REQ-008 SHALL have ports i_m_ADDR  in  NUM_MASTERS*ADDR_WIDTH, i_m_DATA  in  NUM_MASTERS*DATA_WIDTH, i_m_SEL  in  NUM_MASTERS*4; slice i is master i.
REQ-009 SHALL have ports o_m_ACK, o_m_ERR  out  NUM_MASTERS  per-master acknowledge and error.
REQ-010 SHALL have port o_m_DATA  out  DATA_WIDTH  read data, broadcast to all masters.
REQ-011 SHALL have slave-side ports o_CYC, o_STB, o_WE  out  1; o_ADDR  out  ADDR_WIDTH; o_DATA  out  DATA_WIDTH; o_SEL  out  4; i_DATA  in  DATA_WIDTH; i_ACK  in  1.
REQ-012 SHALL have port o_grant  out  NUM_MASTERS  one-hot current owner; all zero when no owner.

Function
REQ-013 SHALL implement states IDLE, BUSY, DRAIN; DRAIN reachable only with WB_ARB_TIMEOUT_EN.
REQ-014 IDLE: if any i_m_CYC high, SHALL register grant to the first requester at index last+1, last+2, ... (wrap mod NUM_MASTERS), where last is the previous owner, and go to BUSY next cycle.
REQ-015 IDLE: with no i_m_CYC high, SHALL stay in IDLE with o_grant = 0.
REQ-016 BUSY: o_CYC, o_STB, o_WE, o_ADDR, o_DATA, o_SEL SHALL combinationally follow owner's i_m_* signals.
REQ-017 Outside BUSY: o_CYC, o_STB, o_WE, o_SEL SHALL be 0; o_ADDR, o_DATA SHALL be 0.
REQ-018 o_m_ACK[i] SHALL equal i_ACK AND o_grant[i] AND state==BUSY; o_m_DATA SHALL equal i_DATA always.
REQ-019 BUSY: owner holds bus across multiple STB/ACK beats while its i_m_CYC stays high; no preemption.
REQ-020 BUSY: when owner's i_m_CYC is low, SHALL record owner as last, clear o_grant, and return to IDLE (one dead cycle between owners).
REQ-021 Requests from non-owners during BUSY SHALL be held pending, not dropped; no ACK reaches them.
REQ-022 Simultaneous new requests in IDLE SHALL be resolved only by the round-robin order of REQ-014.
REQ-023 i_ACK arriving outside BUSY SHALL be ignored.

Reset
REQ-024 Asserting i_RSTN low SHALL immediately, regardless of clock, force state IDLE, o_grant 0, last = NUM_MASTERS-1 (master 0 wins first), timeout counter 0.
REQ-025 Reset mid-transfer SHALL drop o_CYC/o_STB the same instant; no o_m_ACK or o_m_ERR is generated for the aborted transfer.
REQ-026 Deassertion SHALL be synchronised so state leaves IDLE no earlier than the second rising i_CLK edge after i_RSTN rises.

Configuration
REQ-027 Macro WB_ARB_TIMEOUT_EN defined: counter SHALL count BUSY cycles with o_STB high and i_ACK low, clear on i_ACK or leaving BUSY; on reaching TIMEOUT_CYCLES SHALL pulse o_m_ERR[owner] for one cycle, enter DRAIN.
REQ-028 DRAIN: slave-side outputs SHALL be 0, o_grant kept; on owner's i_m_CYC low SHALL record last and go to IDLE.
REQ-029 Macro not defined: SHALL contain no counter or DRAIN logic; o_m_ERR SHALL be tied 0; a stalled slave holds the bus indefinitely.

Verification
REQ-030 Reset, then master 2 CYC/STB write addr 0x100 data 0xDEADBEEF, i_ACK 2 cycles later -> o_grant=0100 cycle after request, slave sees addr/data, o_m_ACK[2] single pulse, others 0.
REQ-031 Masters 0,1,3 request same cycle after reset, each 1 beat -> grant order 0,1,3, one dead IDLE cycle between owners.
REQ-032 Master 1 holds CYC for 4 beats while master 0 requests -> all 4 ACKs to master 1 only; master 0 granted in IDLE after master 1 CYC falls.
REQ-033 Master 0 owns bus, i_RSTN pulsed low mid-STB asynchronously -> o_CYC=0 before next clock edge, o_grant=0, no ACK; after release master 0 regranted first.
REQ-034 WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, master 3 read with i_ACK held 0 -> o_m_ERR[3] pulses once after 8 stalled cycles, o_STB=0, DRAIN until master 3 CYC low; without macro bus stays held, o_m_ERR=0.
